// File: rtl/pdt_pkg.sv
// Shared types and constants for the phase delay trigger.
// FSM encoding, repeat-counter width and the minimum usable period.
package pdt_pkg;

  localparam int REP_W      = 8;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/pdt_channel.sv
// One trigger channel: delay compare, pulse stretcher, config error.
// The delay and error flag are captured on arm and held for the burst.
module pdt_channel #(
  parameter int DELAY_W = 32,
  parameter int PULSE_W = 8
) (
  input  logic               sclock,
  input  logic               rst,
  input  logic               arm,
  input  logic               run,
  input  logic [DELAY_W-1:0] delay_in,
  input  logic [DELAY_W-1:0] period_eff,
  input  logic [DELAY_W-1:0] timebase,
  input  logic [PULSE_W-1:0] pulse_len,
  output logic               trigger,
  output logic               cfg_err
);

  logic [DELAY_W-1:0] delay_q;
  logic [PULSE_W-1:0] cnt;
  logic               fire;

  // A channel in error never matches; the timebase stays below the
  // period anyway, the gate keeps intent explicit.
  assign fire = run && !cfg_err && (timebase == delay_q);

  // Capture config on arm; (re)start the pulse on a fire, else count down.
  always_ff @(posedge sclock or posedge rst) begin
    if (rst) begin
      delay_q <= '0;
      cfg_err <= 1'b0;
      trigger <= 1'b0;
      cnt     <= '0;
    end else begin
      if (arm) begin
        delay_q <= delay_in;
        cfg_err <= (delay_in >= period_eff);
      end
      if (fire) begin
        trigger <= 1'b1;
        cnt     <= pulse_len - 1'b1;
      end else if (trigger) begin
        if (cnt == '0) begin
          trigger <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phase_delay_trigger.sv
// Multi-channel phase-delayed trigger generator with burst control.
// Optional abort input is enabled by defining PDT_ABORT_EN.
import pdt_pkg::*;

module phase_delay_trigger #(
  parameter int NUM_CH  = 4,
  parameter int DELAY_W = 32,
  parameter int PULSE_W = 8
) (
  input  logic                      sclock,
  input  logic                      rst,
  input  logic                      rt,
  input  logic [NUM_CH*DELAY_W-1:0] cfg_delay,
  input  logic [DELAY_W-1:0]        cfg_period,
  input  logic [7:0]                cfg_repeat,
  input  logic [PULSE_W-1:0]        cfg_pulse_len,
  output logic [NUM_CH-1:0]         trigger,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_CH-1:0]         cfg_err
`ifdef PDT_ABORT_EN
  ,
  input  logic                      abort
`endif
);

  state_t             state;
  logic               rt_q;
  logic               rt_low;
  logic               arm_edge;
  logic               arm;
  logic               run;
  logic               wrap;
  logic               abort_req;
  logic [DELAY_W-1:0] timebase;
  logic [DELAY_W-1:0] period_q;
  logic [DELAY_W-1:0] period_in;
  logic [REP_W-1:0]   pcnt;
  logic [REP_W-1:0]   pcnt_nxt;
  logic [REP_W-1:0]   repeat_q;
  logic [PULSE_W-1:0] pulse_q;
  logic [PULSE_W-1:0] pulse_in;

`ifdef PDT_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // rt_low blocks an arm until rt has been seen low since reset.
  assign arm_edge  = rt && !rt_q && rt_low;
  assign arm       = (state == ST_IDLE) && arm_edge;
  assign run       = (state == ST_RUN);
  assign wrap      = (timebase == period_q - 1'b1);
  assign pcnt_nxt  = (&pcnt) ? pcnt : pcnt + 1'b1;

  assign period_in = (cfg_period < DELAY_W'(MIN_PERIOD))
                   ? DELAY_W'(MIN_PERIOD) : cfg_period;
  assign pulse_in  = (cfg_pulse_len == '0)
                   ? PULSE_W'(1) : cfg_pulse_len;

  // Registered copy of rt for edge detection, plus low-seen flag.
  always_ff @(posedge sclock or posedge rst) begin
    if (rst) begin
      rt_q   <= 1'b0;
      rt_low <= 1'b0;
    end else begin
      rt_q <= rt;
      if (!rt) begin
        rt_low <= 1'b1;
      end
    end
  end

  // Burst FSM with timebase, period counter and registered status.
  always_ff @(posedge sclock or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      timebase <= '0;
      pcnt     <= '0;
      period_q <= DELAY_W'(MIN_PERIOD);
      repeat_q <= '0;
      pulse_q  <= PULSE_W'(1);
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arm) begin
            state    <= ST_RUN;
            timebase <= '0;
            pcnt     <= '0;
            period_q <= period_in;
            repeat_q <= cfg_repeat;
            pulse_q  <= pulse_in;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            state <= ST_FLUSH;
          end else if (wrap) begin
            timebase <= '0;
            pcnt     <= pcnt_nxt;
            if (repeat_q != '0) begin
              if (pcnt_nxt == repeat_q) begin
                state <= ST_FLUSH;
              end
            end else if (!rt) begin
              state <= ST_FLUSH;
            end
          end else begin
            timebase <= timebase + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (trigger == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pdt_channel #(
      .DELAY_W (DELAY_W),
      .PULSE_W (PULSE_W)
    ) u_ch (
      .sclock     (sclock),
      .rst        (rst),
      .arm        (arm),
      .run        (run),
      .delay_in   (cfg_delay[i*DELAY_W +: DELAY_W]),
      .period_eff (period_in),
      .timebase   (timebase),
      .pulse_len  (pulse_q),
      .trigger    (trigger[i]),
      .cfg_err    (cfg_err[i])
    );
  end

endmodule

// File: tb/tb_phase_delay_trigger.sv
// Directed self-checking bench for phase_delay_trigger (2 channels).
// Cycle k counts negedges after the arming posedge (k=0: timebase 0).
module tb_phase_delay_trigger;

  localparam int NC = 2;
  localparam int DW = 16;
  localparam int PW = 8;

  logic           sclock = 1'b0;
  logic           rst;
  logic           rt;
  logic [NC*DW-1:0] cfg_delay;
  logic [DW-1:0]  cfg_period;
  logic [7:0]     cfg_repeat;
  logic [PW-1:0]  cfg_pulse_len;
  logic [NC-1:0]  trigger;
  logic           busy;
  logic           done;
  logic [NC-1:0]  cfg_err;
`ifdef PDT_ABORT_EN
  logic           abort;
`endif

  int n_cmp = 0;
  int n_err = 0;

  phase_delay_trigger #(
    .NUM_CH  (NC),
    .DELAY_W (DW),
    .PULSE_W (PW)
  ) dut (
    .sclock        (sclock),
    .rst           (rst),
    .rt            (rt),
    .cfg_delay     (cfg_delay),
    .cfg_period    (cfg_period),
    .cfg_repeat    (cfg_repeat),
    .cfg_pulse_len (cfg_pulse_len),
    .trigger       (trigger),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
`ifdef PDT_ABORT_EN
    ,
    .abort         (abort)
`endif
  );

  always #5 sclock = ~sclock;

  function automatic bit win(int k, int a, int b);
    return (k >= a) && (k <= b);
  endfunction

  task automatic setup(int d0, int d1, int per, int rep, int pl);
    cfg_delay     = {DW'(d1), DW'(d0)};
    cfg_period    = DW'(per);
    cfg_repeat    = 8'(rep);
    cfg_pulse_len = PW'(pl);
  endtask

  task automatic go_idle();
    rt = 1'b0;
    repeat (3) @(negedge sclock);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rt  = 1'b0;
    setup(0, 0, 10, 1, 1);
`ifdef PDT_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge sclock);
    n_cmp++;
    if ({trigger, busy, done, cfg_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outs got %b want 0",
               {trigger, busy, done, cfg_err});
    end
    rst = 1'b0;
    go_idle();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [NC-1:0] et;
    setup(0, 5, 10, 2, 3);
    rt = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      @(negedge sclock);
      et[0] = win(k, 1, 3) || win(k, 11, 13);
      et[1] = win(k, 6, 8) || win(k, 16, 18);
      n_cmp++;
      if (trigger !== et) begin
        n_err++;
        $display("FAIL basic_trig k=%0d got %b want %b", k, trigger, et);
      end
      n_cmp++;
      if (busy !== (k <= 20) || done !== (k == 21)) begin
        n_err++;
        $display("FAIL basic_stat k=%0d busy/done got %b%b want %b%b",
                 k, busy, done, k <= 20, k == 21);
      end
      if (k == 2) setup(1, 1, 3, 5, 9);
      if (k == 3) rt = 1'b0;
      if (k == 5) rt = 1'b1;
    end
    n_cmp++;
    if (cfg_err !== 2'b00) begin
      n_err++;
      $display("FAIL basic_err got %b want 00", cfg_err);
    end
    go_idle();
  endtask

  task automatic test_cfg_err();
    setup(12, 3, 10, 1, 2);
    rt = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      @(negedge sclock);
      n_cmp++;
      if (trigger !== {win(k, 4, 5), 1'b0}) begin
        n_err++;
        $display("FAIL err_trig k=%0d got %b want %b",
                 k, trigger, {win(k, 4, 5), 1'b0});
      end
      n_cmp++;
      if (cfg_err !== 2'b01) begin
        n_err++;
        $display("FAIL err_flag k=%0d got %b want 01", k, cfg_err);
      end
      n_cmp++;
      if (busy !== (k <= 10) || done !== (k == 11)) begin
        n_err++;
        $display("FAIL err_stat k=%0d busy/done got %b%b", k, busy, done);
      end
    end
    go_idle();
  endtask

  task automatic test_overlap();
    logic [NC-1:0] et;
    setup(0, 9, 10, 3, 15);
    rt = 1'b1;
    for (int k = 0; k <= 48; k++) begin
      @(negedge sclock);
      et = {win(k, 10, 44), win(k, 1, 35)};
      n_cmp++;
      if (trigger !== et) begin
        n_err++;
        $display("FAIL ovl_trig k=%0d got %b want %b", k, trigger, et);
      end
      n_cmp++;
      if (busy !== (k <= 45) || done !== (k == 46)) begin
        n_err++;
        $display("FAIL ovl_stat k=%0d busy/done got %b%b", k, busy, done);
      end
    end
    n_cmp++;
    if (cfg_err !== 2'b00) begin
      n_err++;
      $display("FAIL ovl_err_clear got %b want 00", cfg_err);
    end
    go_idle();
  endtask

  task automatic test_min_period();
    logic [NC-1:0] et;
    setup(1, 0, 1, 2, 1);
    rt = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge sclock);
      et = {(k == 1 || k == 3), (k == 2 || k == 4)};
      n_cmp++;
      if (trigger !== et) begin
        n_err++;
        $display("FAIL minp_trig k=%0d got %b want %b", k, trigger, et);
      end
      n_cmp++;
      if (busy !== (k <= 5) || done !== (k == 6)) begin
        n_err++;
        $display("FAIL minp_stat k=%0d busy/done got %b%b", k, busy, done);
      end
    end
    go_idle();
  endtask

  task automatic test_free_run();
    setup(1, 12, 10, 0, 0);
    rt = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      @(negedge sclock);
      n_cmp++;
      if (trigger !== {1'b0, (k == 2 || k == 12 || k == 22)}) begin
        n_err++;
        $display("FAIL free_trig k=%0d got %b", k, trigger);
      end
      n_cmp++;
      if (busy !== (k <= 30) || done !== (k == 31)) begin
        n_err++;
        $display("FAIL free_stat k=%0d busy/done got %b%b", k, busy, done);
      end
      if (k == 23) rt = 1'b0;
    end
    n_cmp++;
    if (cfg_err !== 2'b10) begin
      n_err++;
      $display("FAIL free_err got %b want 10", cfg_err);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    bit seen;
    setup(2, 12, 10, 2, 3);
    rt = 1'b1;
    for (int k = 0; k <= 14; k++) @(negedge sclock);
    n_cmp++;
    if (trigger !== 2'b01 || busy !== 1'b1 || cfg_err !== 2'b10) begin
      n_err++;
      $display("FAIL rmid_pre got t=%b b=%b e=%b want 01 1 10",
               trigger, busy, cfg_err);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({trigger, busy, done, cfg_err} !== '0) begin
      n_err++;
      $display("FAIL rmid_async got %b want 0",
               {trigger, busy, done, cfg_err});
    end
    repeat (2) @(negedge sclock);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge sclock);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL rmid_norearm k=%0d busy/done got %b%b", k, busy, done);
      end
    end
    rt = 1'b0;
    @(negedge sclock);
    rt = 1'b1;
    @(negedge sclock);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_rearm busy got %b want 1", busy);
    end
    rt = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge sclock);
      if (done === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL rmid_done got timeout want done");
    end
    go_idle();
  endtask

`ifdef PDT_ABORT_EN
  task automatic test_abort();
    setup(2, 3, 10, 3, 4);
    rt = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      @(negedge sclock);
      n_cmp++;
      if (trigger !== {win(k, 4, 7), win(k, 3, 6)}) begin
        n_err++;
        $display("FAIL abort_trig k=%0d got %b", k, trigger);
      end
      n_cmp++;
      if (busy !== (k <= 8) || done !== (k == 9)) begin
        n_err++;
        $display("FAIL abort_stat k=%0d busy/done got %b%b", k, busy, done);
      end
      if (k == 3) abort = 1'b1;
      if (k == 4) abort = 1'b0;
    end
    go_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_cfg_err();
    test_overlap();
    test_min_period();
    test_free_run();
    test_reset_mid();
`ifdef PDT_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
